poly_sine_reader: RTL and testbench

POLY_SINE_READER -- requirements
Module: poly_sine_reader

---
 rtl/poly_sine_reader.sv | 214 +++++++++++++++++++++
 tb/tb_poly_sine_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sine_reader.sv
// Time-multiplexed polyphonic sine reader: one phase accumulator per voice,
// one shared quarter-wave ROM visited by one voice per clock, and a mixer
// that produces a single 16-bit sample per request.
//
// Request handshake: generate_next is a request that is accepted only when
// the block is idle (busy low). A request seen while busy, including in the
// final DONE cycle, is dropped and latches the sticky missed flag. Each
// accepted request yields exactly one sample_ready strobe. sample is valid
// while sample_ready is high and holds its value until the next strobe.
// A synchronous consumer sees the strobe at the VOICES+3'th rising edge
// after the accepting edge.

// Quarter-wave sine table, registered output, one cycle latency.
// Word i holds 32767*f(t) with t = (2i+1)/2^(AW+1) and f(t) = (3t - t^3)/2,
// a cubic that rises monotonically from ~0 to 1 with zero slope at the top,
// so mirroring the address rebuilds a smooth full wave.
module sine_rom #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [15:0]   data
);
   localparam int DW = AW + 1;

   logic [63:0] u;
   logic [63:0] num;
   logic [15:0] word;

   // Table contents evaluated from the address with integer arithmetic.
   always_comb begin
      u    = {{(63 - AW){1'b0}}, addr, 1'b1};
      num  = u * ((64'd3 << (2 * DW)) - u * u);
      word = 16'((num * 64'd32767) >> (3 * DW + 1));
   end

   // Output register of the ROM.
   always_ff @(posedge clk) begin
      data <= word;
   end
endmodule

module poly_sine_reader #(
   parameter int VOICES   = 4,
   parameter int STEP_W   = 20,
   parameter int PHASE_W  = 22,
   parameter int ROM_AW   = 10,
   parameter int MIX_MODE = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [VOICES*STEP_W-1:0] step_size,
   input  logic [VOICES-1:0]        voice_en,
   input  logic [VOICES-1:0]        phase_clr,
   input  logic                     generate_next,
   output logic                     busy,
   output logic                     sample_ready,
   output logic signed [15:0]       sample,
   output logic                     missed
);
   localparam int LOGV  = $clog2(VOICES);
   localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int ACC_W = 16 + LOGV;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // state_q is the single point to observe the sequencer from outside.
   state_t                    state_q;
   logic [IDX_W-1:0]          idx_q;
   logic                      busy_q;
   logic                      sample_ready_q;
   logic signed [15:0]        sample_q;
   logic                      missed_q;

   logic [PHASE_W-1:0]        phase_q [VOICES];
   logic signed [ACC_W-1:0]   acc_q;
   logic                      term_vld_q;
   logic                      term_neg_q;

   logic [ROM_AW-1:0]         rom_addr;
   logic [15:0]               rom_data;
   logic signed [ACC_W-1:0]   term_mag;
   logic signed [ACC_W-1:0]   term;
   logic signed [15:0]        mix_val;

   // Quadrant folding: the second bit from the top mirrors the address.
   always_comb begin
      rom_addr = phase_q[idx_q][PHASE_W-3 -: ROM_AW];
      if (phase_q[idx_q][PHASE_W-2]) begin
         rom_addr = ~rom_addr;
      end
   end

   sine_rom #(
      .AW (ROM_AW)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   // ROM word of the previous slot, negated for the lower half-wave.
   always_comb begin
      term_mag = ACC_W'(rom_data);
      term     = term_neg_q ? -term_mag : term_mag;
   end

   // Final mix from the completed accumulator (valid throughout DONE).
   always_comb begin
      mix_val = '0;
      if (MIX_MODE == 0) begin
         mix_val = 16'(acc_q >>> LOGV);
      end else if (acc_q > SAT_HI) begin
         mix_val = 16'sh7fff;
      end else if (acc_q < SAT_LO) begin
         mix_val = -16'sh8000;
      end else begin
         mix_val = 16'(acc_q);
      end
   end

   // Request sequencer with registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         busy_q         <= 1'b0;
         sample_ready_q <= 1'b0;
         sample_q       <= '0;
         missed_q       <= 1'b0;
      end else begin
         sample_ready_q <= 1'b0;
         if (generate_next && (state_q != ST_IDLE)) begin
            missed_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (generate_next) begin
                  state_q <= ST_READ;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
               end
            end
            ST_READ: begin
               if (idx_q == IDX_W'(VOICES - 1)) begin
                  state_q <= ST_DRAIN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DRAIN: begin
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               state_q        <= ST_IDLE;
               busy_q         <= 1'b0;
               sample_q       <= mix_val;
               sample_ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // ROM side-band pipeline and accumulator; a slot's word is added one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         term_vld_q <= 1'b0;
         term_neg_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         term_vld_q <= (state_q == ST_READ) && voice_en[idx_q];
         term_neg_q <= phase_q[idx_q][PHASE_W-1];
         if ((state_q == ST_IDLE) && generate_next) begin
            acc_q <= '0;
         end else if (term_vld_q) begin
            acc_q <= acc_q + term;
         end
      end
   end

   // Phase accumulators: advance in the voice's own slot, clear wins over advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < VOICES; k++) begin
            phase_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < VOICES; k++) begin
            if (phase_clr[k]) begin
               phase_q[k] <= '0;
            end else if ((state_q == ST_READ) && (idx_q == IDX_W'(k)) && voice_en[k]) begin
               phase_q[k] <= phase_q[k] + PHASE_W'(step_size[k*STEP_W +: STEP_W]);
            end
         end
      end
   end

   assign busy         = busy_q;
   assign sample_ready = sample_ready_q;
   assign sample       = sample_q;
   assign missed       = missed_q;
endmodule

// File: tb/tb_poly_sine_reader.sv
// Bench for poly_sine_reader: two instances (averaging and saturating mix)
// share every input so each request checks both mixing rules at once.
module tb_poly_sine_reader;
   localparam int V    = 4;
   localparam int SW   = 22;
   localparam int PW   = 22;
   localparam int AW   = 10;
   localparam int LAT  = V + 3;
   localparam int NRND = 40;

   localparam logic [V*SW-1:0] ST_V0  = 88'h100000;
   localparam logic [V*SW-1:0] ST_ALL = {4{22'h100000}};
   localparam logic [V*SW-1:0] ST_V03 = 88'h300000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [V*SW-1:0]   step_size = '0;
   logic [V-1:0]      voice_en = '0;
   logic [V-1:0]      phase_clr = '0;
   logic              generate_next = 1'b0;

   logic              busy_a, sr_a, miss_a;
   logic signed [15:0] smp_a;
   logic              busy_s, sr_s, miss_s;
   logic signed [15:0] smp_s;

   int n_cmp = 0;
   int n_fail = 0;

   longint      rom_tab [1024];
   int unsigned m_phase [V];

   typedef struct {
      bit              rst;
      logic [V*SW-1:0] steps;
      logic [V-1:0]    en;
      int              exp_avg;
      int              exp_sat;
   } vec_t;

   vec_t vecs [14];

   poly_sine_reader #(
      .VOICES(V), .STEP_W(SW), .PHASE_W(PW), .ROM_AW(AW), .MIX_MODE(0)
   ) u_avg (
      .clk(clk), .reset_n(reset_n), .step_size(step_size), .voice_en(voice_en),
      .phase_clr(phase_clr), .generate_next(generate_next), .busy(busy_a),
      .sample_ready(sr_a), .sample(smp_a), .missed(miss_a)
   );

   poly_sine_reader #(
      .VOICES(V), .STEP_W(SW), .PHASE_W(PW), .ROM_AW(AW), .MIX_MODE(1)
   ) u_sat (
      .clk(clk), .reset_n(reset_n), .step_size(step_size), .voice_en(voice_en),
      .phase_clr(phase_clr), .generate_next(generate_next), .busy(busy_s),
      .sample_ready(sr_s), .sample(smp_s), .missed(miss_s)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      generate_next = 1'b0;
      phase_clr = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < V; k++) m_phase[k] = 0;
   endtask

   // One request from idle, observed for 20 cycles after the accepting edge.
   // Index i is the negedge inside the cycle ending at edge A+i.
   task automatic do_request(input logic [V-1:0] clr_mask, input bit pulse_busy,
                             output int lat, output int lat_s, output int nstr,
                             output int s_avg, output int s_sat);
      lat = 0; lat_s = 0; nstr = 0; s_avg = 0; s_sat = 0;
      @(negedge clk);
      generate_next = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            generate_next = 1'b0;
            phase_clr = clr_mask;
            check("busy_after_accept", longint'(busy_a), 1);
         end
         if (i == 2) begin
            phase_clr = '0;
            if (pulse_busy) generate_next = 1'b1;
         end
         if (i == 3) generate_next = 1'b0;
         if (i == 6 && pulse_busy) generate_next = 1'b1;
         if (i == 7) generate_next = 1'b0;
         if (sr_a) begin
            nstr++;
            if (lat == 0) begin
               lat = i;
               s_avg = smp_a;
            end
         end
         if (sr_s && lat_s == 0) begin
            lat_s = i;
            s_sat = smp_s;
         end
      end
   endtask

   task automatic req_check(input string tag, input logic [V-1:0] clr_mask,
                            input int exp_avg, input int exp_sat);
      int lat, lat_s, nstr, s_avg, s_sat;
      do_request(clr_mask, 1'b0, lat, lat_s, nstr, s_avg, s_sat);
      check({tag, "_lat_avg"}, lat, LAT);
      check({tag, "_lat_sat"}, lat_s, LAT);
      check({tag, "_strobes"}, nstr, 1);
      check({tag, "_avg"}, s_avg, exp_avg);
      check({tag, "_sat"}, s_sat, exp_sat);
   endtask

   // Reference sine: quadrant from the phase value, table index within the quadrant.
   function automatic longint sine_of(input int unsigned ph);
      int unsigned quad;
      int unsigned j;
      longint v;
      quad = ph / (1 << 20);
      j = (ph % (1 << 20)) / 1024;
      if (quad == 1 || quad == 3) j = 1023 - j;
      v = rom_tab[j];
      if (quad >= 2) v = -v;
      return v;
   endfunction

   function automatic int floor_div4(input longint a);
      if (a >= 0) return int'(a / 4);
      return int'(-((-a + 3) / 4));
   endfunction

   function automatic int clamp16(input longint a);
      if (a > 32767) return 32767;
      if (a < -32768) return -32768;
      return int'(a);
   endfunction

   initial begin
      int lat, lat_s, nstr, s_avg, s_sat;
      int unsigned stp [V];
      logic [V-1:0] en;
      logic [V-1:0] clr;
      longint acc;
      string tag;

      // Table of cubic quarter-wave words 32767*(3t - t^3)/2, t = (2j+1)/2048.
      for (int j = 0; j < 1024; j++) begin
         longint u, d;
         u = 2 * j + 1;
         d = 2048;
         rom_tab[j] = (32767 * u * (3 * d * d - u * u)) / (2 * d * d * d);
      end

      vecs[0]  = '{1'b1, '0,     4'hF,     23,     92};
      vecs[1]  = '{1'b1, ST_V0,  4'h1,      5,     23};
      vecs[2]  = '{1'b0, ST_V0,  4'h1,   8191,  32766};
      vecs[3]  = '{1'b0, '0,     4'h1,     -6,    -23};
      vecs[4]  = '{1'b1, ST_ALL, 4'hF,     23,     92};
      vecs[5]  = '{1'b0, ST_ALL, 4'hF,  32766,  32767};
      vecs[6]  = '{1'b0, ST_ALL, 4'hF,    -23,    -92};
      vecs[7]  = '{1'b0, ST_ALL, 4'hF, -32766, -32768};
      vecs[8]  = '{1'b0, ST_ALL, 4'hF,     23,     92};
      vecs[9]  = '{1'b1, ST_V03, 4'h1,      5,     23};
      vecs[10] = '{1'b0, ST_V03, 4'h1,  -8192, -32766};
      vecs[11] = '{1'b0, ST_V03, 4'h1,     -6,    -23};
      vecs[12] = '{1'b0, ST_V03, 4'h1,   8191,  32766};
      vecs[13] = '{1'b1, '0,     4'h5,     11,     46};

      // Reset state
      apply_reset();
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_ready", sr_a, 0);
      check("rst_sample_avg", smp_a, 0);
      check("rst_sample_sat", smp_s, 0);
      check("rst_missed", miss_a, 0);

      // Directed table
      for (int r = 0; r < 14; r++) begin
         if (vecs[r].rst) apply_reset();
         step_size = vecs[r].steps;
         voice_en = vecs[r].en;
         tag = $sformatf("vec%0d", r);
         req_check(tag, '0, vecs[r].exp_avg, vecs[r].exp_sat);
      end
      check("missed_clean_avg", miss_a, 0);
      check("missed_clean_sat", miss_s, 0);

      // Requests while busy (READ and DONE) are dropped
      apply_reset();
      step_size = '0;
      voice_en = 4'hF;
      do_request('0, 1'b1, lat, lat_s, nstr, s_avg, s_sat);
      check("drop_lat", lat, LAT);
      check("drop_strobes", nstr, 1);
      check("drop_avg", s_avg, 23);
      check("drop_sat", s_sat, 92);
      check("drop_missed_avg", miss_a, 1);
      check("drop_missed_sat", miss_s, 1);

      // phase_clr during slot 0 overrides that slot's advance
      apply_reset();
      step_size = ST_V0;
      voice_en = 4'h1;
      req_check("clr_r1", '0, 5, 23);
      req_check("clr_r2", 4'h1, 8191, 32766);
      step_size = '0;
      req_check("clr_r3", '0, 5, 23);

      // Reset in READ slot 2 aborts the request
      apply_reset();
      step_size = ST_ALL;
      voice_en = 4'hF;
      req_check("abort_pre", '0, 23, 92);
      @(negedge clk);
      generate_next = 1'b1;
      @(negedge clk);
      generate_next = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_busy", busy_a, 0);
      check("abort_sample_avg", smp_a, 0);
      check("abort_sample_sat", smp_s, 0);
      check("abort_ready", sr_a, 0);
      nstr = 0;
      repeat (4) begin
         @(negedge clk);
         if (sr_a || sr_s) nstr++;
      end
      reset_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (sr_a || sr_s) nstr++;
      end
      check("abort_no_strobe", nstr, 0);
      step_size = '0;
      req_check("abort_post", '0, 23, 92);

      // Randomized requests against the reference model
      apply_reset();
      for (int n = 0; n < NRND; n++) begin
         for (int k = 0; k < V; k++) begin
            stp[k] = $urandom_range(0, (1 << SW) - 1);
            step_size[k*SW +: SW] = SW'(stp[k]);
         end
         en = V'($urandom_range(0, (1 << V) - 1));
         voice_en = en;
         if ($urandom_range(0, 5) == 0) begin
            clr = V'($urandom_range(1, (1 << V) - 1));
            @(negedge clk);
            phase_clr = clr;
            @(negedge clk);
            phase_clr = '0;
            for (int k = 0; k < V; k++) if (clr[k]) m_phase[k] = 0;
         end
         acc = 0;
         for (int k = 0; k < V; k++) begin
            if (en[k]) begin
               acc += sine_of(m_phase[k]);
               m_phase[k] = (m_phase[k] + stp[k]) % (1 << PW);
            end
         end
         tag = $sformatf("rnd%0d", n);
         req_check(tag, '0, floor_div4(acc), clamp16(acc));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      check("rnd_missed", miss_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
